// File: rtl/mtr_pwm_drv.sv
// Dual-channel H-bridge PWM driver.
// A free-running 11-bit counter defines a 2048-clock PWM period. Each channel
// (left, right) samples its duty and direction at the period start. A small FSM
// per channel enforces a dead interval of DEAD_PERIODS whole periods on every
// direction change, so the forward and reverse gates of one bridge are never
// driven together. All gate outputs and the period-start strobe are registered.
module mtr_pwm_drv #(
    parameter int DEAD_PERIODS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwr_up,
    input  logic [10:0] lft_spd,
    input  logic        lft_rev,
    input  logic [10:0] rght_spd,
    input  logic        rght_rev,
    output logic        lft_fwd_pwm,
    output logic        lft_rev_pwm,
    output logic        rght_fwd_pwm,
    output logic        rght_rev_pwm,
    output logic        prd_strt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } ch_state_t;

    // Value loaded into the dead counter on entry to DEAD; the last dead period
    // is the one in which the counter reads zero.
    localparam logic [2:0] DEAD_LOAD = 3'(DEAD_PERIODS - 1);

    logic [10:0] cnt_reg;
    logic        prd_zero;
    logic        prd_strt_reg;

    // Per-channel views of the inputs/outputs; index 0 = left, 1 = right.
    logic [10:0] spd_vec [2];
    logic [1:0]  rev_vec;
    logic [1:0]  fwd_pwm_vec;
    logic [1:0]  rev_pwm_vec;

    assign spd_vec[0] = lft_spd;
    assign spd_vec[1] = rght_spd;
    assign rev_vec    = {rght_rev, lft_rev};

    // Free-running period counter; wraps naturally from 2047 to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 11'd1;
        end
    end

    assign prd_zero = (cnt_reg == 11'd0);

    // Period-start strobe, registered so it lines up with the gate outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prd_strt_reg <= 1'b0;
        end else begin
            prd_strt_reg <= prd_zero;
        end
    end

    assign prd_strt = prd_strt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            ch_state_t   state_reg;
            ch_state_t   state_next;
            logic        dir_act_reg;
            logic        dir_act_next;
            logic [2:0]  dead_cnt_reg;
            logic [2:0]  dead_cnt_next;
            logic [10:0] duty_sh_reg;
            logic        raw_fwd;
            logic        raw_rev;
            logic        fwd_pwm_reg;
            logic        rev_pwm_reg;
            logic        duty_hit;

            // Shadow duty: captured only at the period start, and not while the
            // channel is being powered down (power-down wins over the latch).
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    duty_sh_reg <= '0;
                end else if (prd_zero && pwr_up) begin
                    duty_sh_reg <= spd_vec[gi];
                end
            end

            // FSM state register together with active direction and dead counter.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg    <= ST_IDLE;
                    dir_act_reg  <= 1'b0;
                    dead_cnt_reg <= '0;
                end else begin
                    state_reg    <= state_next;
                    dir_act_reg  <= dir_act_next;
                    dead_cnt_reg <= dead_cnt_next;
                end
            end

            // Next-state logic: power loss acts on any clock, everything else
            // only at the period start. The direction sampled at that boundary
            // is compared directly against the active one.
            always_comb begin
                state_next    = state_reg;
                dir_act_next  = dir_act_reg;
                dead_cnt_next = dead_cnt_reg;
                if (!pwr_up) begin
                    state_next    = ST_IDLE;
                    dead_cnt_next = '0;
                end else if (prd_zero) begin
                    case (state_reg)
                        ST_IDLE: begin
                            dir_act_next = rev_vec[gi];
                            state_next   = ST_RUN;
                        end
                        ST_RUN: begin
                            if (rev_vec[gi] != dir_act_reg) begin
                                dead_cnt_next = DEAD_LOAD;
                                state_next    = ST_DEAD;
                            end
                        end
                        ST_DEAD: begin
                            // A direction that flips back meanwhile does not
                            // shorten the dead time.
                            if (dead_cnt_reg == 3'd0) begin
                                dir_act_next = rev_vec[gi];
                                state_next   = ST_RUN;
                            end else begin
                                dead_cnt_next = dead_cnt_reg - 3'd1;
                            end
                        end
                        default: begin
                            state_next    = ST_IDLE;
                            dead_cnt_next = '0;
                        end
                    endcase
                end
            end

            // Output decode: only RUN drives, and only the line selected by the
            // active direction. Gating with pwr_up kills the drive on the very
            // next registered output.
            always_comb begin
                duty_hit = (cnt_reg < duty_sh_reg);
                raw_fwd  = 1'b0;
                raw_rev  = 1'b0;
                if (pwr_up && (state_reg == ST_RUN) && duty_hit) begin
                    raw_fwd = ~dir_act_reg;
                    raw_rev = dir_act_reg;
                end
            end

            // Registered gate outputs, glitch-free toward the bridge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    fwd_pwm_reg <= 1'b0;
                    rev_pwm_reg <= 1'b0;
                end else begin
                    fwd_pwm_reg <= raw_fwd;
                    rev_pwm_reg <= raw_rev;
                end
            end

            assign fwd_pwm_vec[gi] = fwd_pwm_reg;
            assign rev_pwm_vec[gi] = rev_pwm_reg;
        end
    endgenerate

    assign lft_fwd_pwm  = fwd_pwm_vec[0];
    assign lft_rev_pwm  = rev_pwm_vec[0];
    assign rght_fwd_pwm = fwd_pwm_vec[1];
    assign rght_rev_pwm = rev_pwm_vec[1];

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Bench for mtr_pwm_drv: a per-period reference model feeds an expectation
// queue each clock; an independent monitor pops and compares every cycle.
// Directed phases measure per-period high counts; a random phase follows.
module tb_mtr_pwm_drv;

    localparam int DEAD = 2;
    localparam int PRD  = 2048;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        pwr_up   = 1'b0;
    logic [10:0] lft_spd  = '0;
    logic        lft_rev  = 1'b0;
    logic [10:0] rght_spd = '0;
    logic        rght_rev = 1'b0;
    logic        lft_fwd_pwm;
    logic        lft_rev_pwm;
    logic        rght_fwd_pwm;
    logic        rght_rev_pwm;
    logic        prd_strt;

    int checks   = 0;
    int failures = 0;

    // Expected {lf, lr, rf, rr, ps} for the cycle after each clock edge.
    logic [4:0] exp_q [$];

    // Reference model: position in the period, and per channel whether it is
    // engaged (powered and past a boundary), its drive direction, its duty and
    // how many more period boundaries it must stay dark.
    int  m_cnt;
    bit  m_eng  [2];
    bit  m_dir  [2];
    int  m_duty [2];
    int  m_dark [2];
    int  sm_spd [2];
    bit  sm_rev [2];
    bit  sm_f   [2];
    bit  sm_r   [2];
    bit  sm_drv;

    logic [4:0] mon_exp;
    logic [4:0] mon_act;

    always #5 clk = ~clk;

    mtr_pwm_drv #(.DEAD_PERIODS(DEAD)) dut (
        .clk          (clk),
        .rst          (rst),
        .pwr_up       (pwr_up),
        .lft_spd      (lft_spd),
        .lft_rev      (lft_rev),
        .rght_spd     (rght_spd),
        .rght_rev     (rght_rev),
        .lft_fwd_pwm  (lft_fwd_pwm),
        .lft_rev_pwm  (lft_rev_pwm),
        .rght_fwd_pwm (rght_fwd_pwm),
        .rght_rev_pwm (rght_rev_pwm),
        .prd_strt     (prd_strt)
    );

    // Model step: expected output after this edge comes from the settings in
    // force before it; then boundary rules update the settings.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0;
            for (int ch = 0; ch < 2; ch++) begin
                m_eng[ch]  = 1'b0;
                m_dir[ch]  = 1'b0;
                m_duty[ch] = 0;
                m_dark[ch] = 0;
            end
            exp_q.push_back(5'b0);
        end else begin
            sm_spd[0] = int'(lft_spd);
            sm_spd[1] = int'(rght_spd);
            sm_rev[0] = lft_rev;
            sm_rev[1] = rght_rev;
            for (int ch = 0; ch < 2; ch++) begin
                sm_drv    = pwr_up && m_eng[ch] && (m_dark[ch] == 0) && (m_cnt < m_duty[ch]);
                sm_f[ch]  = sm_drv && !m_dir[ch];
                sm_r[ch]  = sm_drv && m_dir[ch];
            end
            exp_q.push_back({sm_f[0], sm_r[0], sm_f[1], sm_r[1], (m_cnt == 0)});
            for (int ch = 0; ch < 2; ch++) begin
                if (!pwr_up) begin
                    m_eng[ch]  = 1'b0;
                    m_dark[ch] = 0;
                end else if (m_cnt == 0) begin
                    m_duty[ch] = sm_spd[ch];
                    if (!m_eng[ch]) begin
                        m_eng[ch] = 1'b1;
                        m_dir[ch] = sm_rev[ch];
                    end else if (m_dark[ch] > 0) begin
                        m_dark[ch] = m_dark[ch] - 1;
                        if (m_dark[ch] == 0) m_dir[ch] = sm_rev[ch];
                    end else if (sm_rev[ch] != m_dir[ch]) begin
                        m_dark[ch] = DEAD;
                    end
                end
            end
            m_cnt = (m_cnt + 1) % PRD;
        end
    end

    // Monitor: compare every presented output against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, prd_strt};
            checks++;
            if (mon_act !== mon_exp) begin
                failures++;
                $display("FAIL scoreboard t=%0t actual=%b required=%b (lf lr rf rr ps)",
                         $time, mon_act, mon_exp);
            end
            checks++;
            if ((lft_fwd_pwm && lft_rev_pwm) || (rght_fwd_pwm && rght_rev_pwm)) begin
                failures++;
                $display("FAIL shoot_through t=%0t actual=%b required=no fwd&rev pair",
                         $time, mon_act);
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic apply(input int which, input int val);
        case (which)
            0:       lft_spd  = 11'(val);
            1:       lft_rev  = val[0];
            2:       rght_spd = 11'(val);
            3:       rght_rev = val[0];
            default: pwr_up   = val[0];
        endcase
    endtask

    // Count high cycles of each output over one period, starting at the next
    // prd_strt; optionally change one input at sample index chg_at.
    task automatic measure(input int chg_at, input int which, input int val,
                           output int lf, output int lr, output int rf,
                           output int rr, output int ps);
        bit ok = 1'b0;
        lf = 0; lr = 0; rf = 0; rr = 0; ps = 0;
        for (int i = 0; i < 2 * PRD + 8 && !ok; i++) begin
            @(negedge clk);
            if (prd_strt === 1'b1) ok = 1'b1;
        end
        chk("prd_strt_wait", int'(ok), 1);
        for (int i = 0; i < PRD; i++) begin
            if (i > 0) @(negedge clk);
            lf += int'(lft_fwd_pwm === 1'b1);
            lr += int'(lft_rev_pwm === 1'b1);
            rf += int'(rght_fwd_pwm === 1'b1);
            rr += int'(rght_rev_pwm === 1'b1);
            ps += int'(prd_strt === 1'b1);
            if (i == chg_at) apply(which, val);
        end
    endtask

    function automatic int pick_spd();
        int sel;
        sel = int'($urandom_range(0, 5));
        if (sel == 0) return 0;
        if (sel == 1) return 2047;
        return int'($urandom_range(0, 2047));
    endfunction

    int lf, lr, rf, rr, ps;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk_bit("rst_lft_fwd", lft_fwd_pwm, 1'b0);
        chk_bit("rst_lft_rev", lft_rev_pwm, 1'b0);
        chk_bit("rst_rght_fwd", rght_fwd_pwm, 1'b0);
        chk_bit("rst_rght_rev", rght_rev_pwm, 1'b0);
        chk_bit("rst_prd_strt", prd_strt, 1'b0);

        // Forward at 512, right idle at duty 0
        pwr_up = 1'b1; lft_spd = 11'd512; lft_rev = 1'b0;
        rght_spd = 11'd0; rght_rev = 1'b0;
        rst = 1'b0;
        measure(-1, 0, 0, lf, lr, rf, rr, ps);
        measure(-1, 0, 0, lf, lr, rf, rr, ps);
        chk("fwd512_lf", lf, 512);
        chk("fwd512_lr", lr, 0);
        chk("duty0_rf", rf, 0);
        chk("duty0_rr", rr, 0);
        chk("prd_strt_once", ps, 1);

        // Duty change mid-period takes effect at the next period
        measure(100, 0, 1024, lf, lr, rf, rr, ps);
        chk("chg_cur_lf", lf, 512);
        measure(-1, 0, 0, lf, lr, rf, rr, ps);
        chk("chg_next_lf", lf, 1024);

        // Forward 1000, then reverse with dead time
        measure(5, 0, 1000, lf, lr, rf, rr, ps);
        measure(-1, 0, 0, lf, lr, rf, rr, ps);
        chk("fwd1000_lf", lf, 1000);
        measure(300, 1, 1, lf, lr, rf, rr, ps);
        chk("pre_rev_lf", lf, 1000);
        measure(-1, 0, 0, lf, lr, rf, rr, ps);
        chk("dead1_lf", lf, 1);
        chk("dead1_lr", lr, 0);
        measure(-1, 0, 0, lf, lr, rf, rr, ps);
        chk("dead2_lf", lf, 0);
        chk("dead2_lr", lr, 0);
        measure(-1, 0, 0, lf, lr, rf, rr, ps);
        chk("rev_first_lf", lf, 0);
        chk("rev_first_lr", lr, 999);
        measure(-1, 0, 0, lf, lr, rf, rr, ps);
        chk("rev1000_lr", lr, 1000);

        // Right channel at maximum duty
        measure(7, 2, 2047, lf, lr, rf, rr, ps);
        chk("r_before_rf", rf, 0);
        measure(-1, 0, 0, lf, lr, rf, rr, ps);
        chk("r_trans_rf", rf, 2046);
        measure(-1, 0, 0, lf, lr, rf, rr, ps);
        chk("r2047_rf", rf, 2047);
        chk("r2047_rr", rr, 0);
        chk("r2047_ps", ps, 1);

        // Power drop mid-high-phase, then resume at the next boundary
        repeat (600) @(negedge clk);
        pwr_up = 1'b0;
        repeat (2) @(negedge clk);
        chk_bit("pwr_off_lf", lft_fwd_pwm, 1'b0);
        chk_bit("pwr_off_lr", lft_rev_pwm, 1'b0);
        chk_bit("pwr_off_rf", rght_fwd_pwm, 1'b0);
        chk_bit("pwr_off_rr", rght_rev_pwm, 1'b0);
        repeat (900) @(negedge clk);
        pwr_up = 1'b1;
        measure(-1, 0, 0, lf, lr, rf, rr, ps);
        chk("resume_rf", rf, 2046);
        chk("resume_lr", lr, 999);

        // Asynchronous reset mid-operation
        repeat (700) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_bit("arst_lf", lft_fwd_pwm, 1'b0);
        chk_bit("arst_lr", lft_rev_pwm, 1'b0);
        chk_bit("arst_rf", rght_fwd_pwm, 1'b0);
        chk_bit("arst_rr", rght_rev_pwm, 1'b0);
        chk_bit("arst_ps", prd_strt, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        measure(-1, 0, 0, lf, lr, rf, rr, ps);
        chk("post_rst_lr", lr, 999);
        chk("post_rst_rf", rf, 2046);

        // Random run: duties, directions and power glitches
        for (int k = 0; k < 36; k++) begin
            repeat ($urandom_range(100, 1500)) @(negedge clk);
            case ($urandom_range(0, 5))
                0: lft_spd  = 11'(pick_spd());
                1: rght_spd = 11'(pick_spd());
                2: lft_rev  = ~lft_rev;
                3: rght_rev = ~rght_rev;
                4: begin
                    lft_rev  = 1'($urandom_range(0, 1));
                    rght_rev = 1'($urandom_range(0, 1));
                end
                default: begin
                    pwr_up = 1'b0;
                    repeat ($urandom_range(1, 50)) @(negedge clk);
                    pwr_up = 1'b1;
                end
            endcase
        end

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
